axi2_mem_slave: RTL and testbench
=================================

Name: axi2_mem_slave

Overview:
- AXI v2.0 slave endpoint that terminates an axi2_if slave modport and serves accesses from an internal word-addressed RAM.
- Sits directly downstream of the interface and consumes all master-driven channels: AW, W, B-ready, AR and R-ready.
- Handles one transaction at a time and supports FIXED, INCR and WRAP bursts of 1–16 beats.
- Serves as the default memory model and scratchpad target for interface-level benches and small SoC builds.

Parameters:
- NUM_DATA_BITS_P, 32, data bus width; must be 32 or 64.
- NUM_ADDR_BITS_P, 32, byte address width.
- NUM_ID_BITS_P, 4, transaction ID width.
- NUM_BURST_BITS_P, 4, AxLEN width; beats = AxLEN+1.
- MEM_WORDS_P, 1024, RAM depth in bus-width words.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  in  per parameters (size 3, burst 2, lock 2, cache 4, prot 3, valid 1)  write address channel.
- awready  out  1  write address accept.
- wid/wdata/wstrb/wlast/wvalid  in  ID/DATA/DATA/8/1/1  write data channel.
- wready  out  1  write data accept.
- bid  out  NUM_ID_BITS_P; bresp  out  2; bvalid  out  1  write response.
- bready  in  1  write response accept.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  in  same widths as AW  read address channel.
- arready  out  1  read address accept.
- rid  out  NUM_ID_BITS_P; rdata  out  NUM_DATA_BITS_P; rresp  out  2; rlast  out  1; rvalid  out  1  read data channel.
- rready  in  1  read data accept.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, pri_w=1, and every output (awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp, rdata) is 0. RAM contents are not reset.
- A reset mid-burst abandons the transaction immediately; no B or R beat is issued for it.

State machine: IDLE, WDATA, WRESP, RDATA.

- IDLE:
  - awready = awvalid & (pri_w | ~arvalid).
  - arready = arvalid & (~pri_w | ~awvalid).
  - At most one of awready/arready is high in any cycle.
  - AW handshake: latch id/addr/len/size/burst, then go to WDATA; pri_w <= 0.
  - AR handshake: latch the same fields, then go to RDATA; pri_w <= 1.
- WDATA:
  - wready=1 on every cycle.
  - Each W handshake writes the bytes enabled by wstrb to word addr>>log2(NUM_DATA_BITS_P/8), then advances the address.
  - Beat count reaches len+1 -> WRESP.
  - wlast is not used to terminate the burst.
- WRESP:
  - bvalid=1, bid = latched awid. bvalid is held with stable bid/bresp until bready.
  - Handshake -> IDLE.
- RDATA:
  - First rvalid rises 1 cycle after the AR handshake, using a registered RAM read.
  - rid = latched arid; rlast=1 on beat len+1.
  - When rvalid=1 and rready=0, rdata/rresp/rlast/rid hold stable.
  - Each R handshake presents the next beat on the following cycle, with no bubble under continuous rready.
  - Last handshake -> IDLE.
- Address advance:
  - FIXED: address unchanged.
  - INCR: address += 2^size. A carry across NUM_ADDR_BITS_P wraps modulo 2^NUM_ADDR_BITS_P.
  - WRAP: boundary = (len+1)*2^size. The address wraps to the aligned base when it crosses the boundary.

Error rules (bresp/rresp = 2'b10 SLVERR; otherwise 2'b00 OKAY):
- Any of the following makes the whole burst SLVERR:
  - word index >= MEM_WORDS_P on any beat;
  - 2^size > NUM_DATA_BITS_P/8;
  - burst == 2'b11;
  - WRAP with len not in {1,3,7,15};
  - wid != latched awid on any beat;
  - wlast asserted on a beat other than the last, or deasserted on the last beat.
- Writes in an erroring burst are not performed on any beat from the offending one onward. Earlier beats stay written.
- Read beats that are out of range return rdata=0 with rresp=SLVERR. All other read beats return RAM data with OKAY.
- Exclusive accesses (lock=2'b01) return OKAY; EXOKAY is never generated and no exclusive monitor is implemented.
- cache and prot are ignored.
- Narrow transfers:
  - Reads return the full word.
  - Writes rely solely on wstrb; no lane check is performed.

Test Plan:
- INCR write of 4 beats at 0x100 (size=2, data 0x11..0x44, wstrb=0xF), then INCR read of 4 beats at 0x100 -> bresp=0, rdata 0x11,0x22,0x33,0x44, rlast only on beat 4, rid=awid.
- Simultaneous awvalid/arvalid after reset -> AW accepted first (pri_w=1). After that transaction, a pending AR wins over a new AW.
- WRAP read with len=3, size=2, addr 0x0C -> word addresses 0x0C, 0x00, 0x04, 0x08. WRAP with len=2 -> all beats SLVERR.
- Write of 1 beat at byte address MEM_WORDS_P*4 -> bresp=2'b10 and no RAM change. Read at the same address -> rdata=0, rresp=2'b10.
- rready toggled 1-0-0-1 during an 8-beat read -> rdata/rlast held stable while stalled, no beats lost, rlast after exactly 8 handshakes. bready held low for 5 cycles -> bvalid and bresp stable.
- aresetn pulsed low during beat 2 of a 4-beat write -> all outputs 0 immediately, state IDLE, next AW accepted normally, beat 1 data retained in RAM.

Source files
------------

// File: rtl/axi2_mem_slave.sv
// AXI slave that serves one burst at a time from an internal word-addressed RAM.
// FIXED/INCR/WRAP bursts; malformed or out-of-range bursts complete with SLVERR.
module axi2_mem_slave #(
  parameter int NUM_DATA_BITS_P  = 32,
  parameter int NUM_ADDR_BITS_P  = 32,
  parameter int NUM_ID_BITS_P    = 4,
  parameter int NUM_BURST_BITS_P = 4,
  parameter int MEM_WORDS_P      = 1024
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_ID_BITS_P-1:0]     awid,
  input  logic [NUM_ADDR_BITS_P-1:0]   awaddr,
  input  logic [NUM_BURST_BITS_P-1:0]  awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic [1:0]                   awlock,
  input  logic [3:0]                   awcache,
  input  logic [2:0]                   awprot,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [NUM_ID_BITS_P-1:0]     wid,
  input  logic [NUM_DATA_BITS_P-1:0]   wdata,
  input  logic [NUM_DATA_BITS_P/8-1:0] wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [NUM_ID_BITS_P-1:0]     bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [NUM_ID_BITS_P-1:0]     arid,
  input  logic [NUM_ADDR_BITS_P-1:0]   araddr,
  input  logic [NUM_BURST_BITS_P-1:0]  arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic [1:0]                   arlock,
  input  logic [3:0]                   arcache,
  input  logic [2:0]                   arprot,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [NUM_ID_BITS_P-1:0]     rid,
  output logic [NUM_DATA_BITS_P-1:0]   rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready
);

  localparam int STRB_W = NUM_DATA_BITS_P / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_WORDS_P > 1) ? $clog2(MEM_WORDS_P) : 1;

  typedef logic [NUM_ADDR_BITS_P-1:0]  addr_t;
  typedef logic [NUM_BURST_BITS_P-1:0] len_t;
  typedef logic [NUM_ID_BITS_P-1:0]    id_t;
  typedef logic [NUM_DATA_BITS_P-1:0]  data_t;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  localparam addr_t MEM_WORDS_A = addr_t'(MEM_WORDS_P);

  function automatic addr_t next_addr(input addr_t a, input logic [2:0] size,
                                      input logic [1:0] burst, input len_t len);
    addr_t incr;
    addr_t wrap_mask;
    incr      = addr_t'(1) << size;
    wrap_mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    case (burst)
      2'b01:   next_addr = a + incr;
      2'b10:   next_addr = (a & ~wrap_mask) | ((a + incr) & wrap_mask);
      default: next_addr = a;
    endcase
  endfunction

  // Burst shapes that can never be served correctly, regardless of address.
  function automatic logic cfg_bad(input logic [2:0] size, input logic [1:0] burst,
                                   input len_t len);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == len_t'(1) || len == len_t'(3) || len == len_t'(7) || len == len_t'(15));
    cfg_bad  = (32'(size) > LSB) || (burst == 2'b11) || bad_wrap;
  endfunction

  function automatic logic word_oor(input addr_t a);
    word_oor = (a >> LSB) >= MEM_WORDS_A;
  endfunction

  state_t state, state_nxt;
  addr_t  addr_q, addr_nxt, rd_addr;
  len_t   len_q, cnt_q;
  id_t    id_q;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic   err_q, cfg_err_q, pri_w;
  logic   aw_hs, ar_hs, w_hs, r_hs, r_advance, beat_last;
  logic   w_beat_err, w_err_nxt, mem_we, rd_oor, rd_cfg_err, ar_cfg_err, aw_cfg_err;
  logic   unused_sideband;
  data_t  mem [MEM_WORDS_P];

  assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    case (state)
      IDLE: begin
        awready = awvalid & (pri_w | ~arvalid);
        arready = arvalid & (~pri_w | ~awvalid);
        if (awready)      state_nxt = WDATA;
        else if (arready) state_nxt = RDATA;
      end
      WDATA: begin
        wready = 1'b1;
        if (wvalid && beat_last) state_nxt = WRESP;
      end
      WRESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      RDATA: begin
        rvalid = 1'b1;
        rlast  = beat_last;
        if (rready && beat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign aw_hs      = awready;
  assign ar_hs      = arready;
  assign w_hs       = wready & wvalid;
  assign r_hs       = rvalid & rready;
  assign r_advance  = r_hs & ~beat_last;
  assign beat_last  = (cnt_q == len_q);
  assign addr_nxt   = next_addr(addr_q, size_q, burst_q, len_q);
  assign aw_cfg_err = cfg_bad(awsize, awburst, awlen);
  assign ar_cfg_err = cfg_bad(arsize, arburst, arlen);

  // Once any beat errs, the sticky flag blocks that beat and every later one.
  assign w_beat_err = cfg_err_q | word_oor(addr_q) | (wid != id_q) | (wlast != beat_last);
  assign w_err_nxt  = err_q | w_beat_err;
  assign mem_we     = w_hs & ~w_err_nxt;

  assign rd_addr    = ar_hs ? araddr : addr_nxt;
  assign rd_cfg_err = ar_hs ? ar_cfg_err : cfg_err_q;
  assign rd_oor     = word_oor(rd_addr);

  assign bid   = id_q;
  assign rid   = id_q;
  assign bresp = {err_q, 1'b0};

  // Read data is fetched on the AR handshake and on every non-final R handshake,
  // so the next beat is ready the following cycle and holds while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      pri_w     <= 1'b1;
      rdata     <= '0;
      rresp     <= 2'b00;
    end else begin
      if (aw_hs) begin
        id_q      <= awid;
        addr_q    <= awaddr;
        len_q     <= awlen;
        size_q    <= awsize;
        burst_q   <= awburst;
        cnt_q     <= '0;
        err_q     <= 1'b0;
        cfg_err_q <= aw_cfg_err;
        pri_w     <= 1'b0;
      end else if (ar_hs) begin
        id_q      <= arid;
        addr_q    <= araddr;
        len_q     <= arlen;
        size_q    <= arsize;
        burst_q   <= arburst;
        cnt_q     <= '0;
        err_q     <= 1'b0;
        cfg_err_q <= ar_cfg_err;
        pri_w     <= 1'b1;
      end
      if (w_hs) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + len_t'(1);
        err_q  <= w_err_nxt;
      end
      if (r_advance) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + len_t'(1);
      end
      if (ar_hs || r_advance) begin
        rdata <= rd_oor ? '0 : mem[rd_addr[LSB +: IDX_W]];
        rresp <= (rd_oor | rd_cfg_err) ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[addr_q[LSB +: IDX_W]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi2_mem_slave.sv
// Bench for axi2_mem_slave: directed and random bursts checked against a
// per-beat address/byte memory model built from the burst rules.
module tb_axi2_mem_slave;

  localparam int MEM_WORDS = 1024;
  localparam int TIMEOUT   = 20;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid, wid, bid, arid, rid, awcache, arcache, wstrb;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [MEM_WORDS];

  always #5 aclk = ~aclk;

  axi2_mem_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [49:0] allOutputs();
    return {awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp, rdata};
  endfunction

  // Address of beat i, written as a closed-form offset rather than a step.
  function automatic logic [31:0] beatAddr(input logic [31:0] addr, input int len, input int size,
                                           input int burst, input int i);
    longint start, incr, wrap_bytes, base;
    start = {32'b0, addr};
    incr  = longint'(1) << size;
    case (burst)
      1: return 32'((start + i * incr) % (longint'(1) << 32));
      2: begin
        wrap_bytes = (len + 1) * incr;
        base = (start / wrap_bytes) * wrap_bytes;
        return 32'(base + (start - base + i * incr) % wrap_bytes);
      end
      default: return addr;
    endcase
  endfunction

  function automatic bit cfgBad(input int len, input int size, input int burst);
    return size > 2 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic bit inRange(input logic [31:0] a);
    return (a >> 2) < MEM_WORDS;
  endfunction

  // data_mode: 0 random data/strobes, 1 random data full strobes, 2 data 0x11*(beat+1).
  task automatic applyWrite(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int data_mode,
                            input int bad_wid_beat, input int bad_wlast_beat, input int b_stall);
    logic [31:0] data, a;
    logic [3:0]  strb;
    bit err;
    int n;
    err = cfgBad(len, size, burst);
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awlock = 2'($urandom_range(0, 1)); awcache = 4'($urandom); awprot = 3'($urandom);
    awvalid = 1'b1;
    #1; n = 0;
    while (!awready && n < TIMEOUT) begin @(negedge aclk); #1; n++; end
    checkOutput("aw_ready", awready, 1);
    if (!awready) begin awvalid = 1'b0; return; end
    for (int i = 0; i <= len; i++) begin
      @(negedge aclk);
      awvalid = 1'b0;
      data = (data_mode == 2) ? 32'h11 * (i + 1) : $urandom;
      strb = (data_mode == 0) ? 4'($urandom) : 4'hF;
      wvalid = 1'b1; wdata = data; wstrb = strb;
      wid = (i == bad_wid_beat) ? id ^ 4'h1 : id;
      wlast = ((i == len) != (i == bad_wlast_beat));
      #1;
      checkOutput("w_ready", wready, 1);
      a = beatAddr(addr, len, size, burst, i);
      err = err || !inRange(a) || i == bad_wid_beat || i == bad_wlast_beat;
      if (!err)
        for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[a[11:2]][8*b +: 8] = data[8*b +: 8];
    end
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    for (int k = 0; k < b_stall; k++) begin
      bready = 1'b0; #1;
      checkOutput("b_valid_stall", bvalid, 1);
      checkOutput("b_resp_stall", bresp, err ? 2'b10 : 2'b00);
      checkOutput("b_id_stall", bid, id);
      @(negedge aclk);
    end
    bready = 1'b1; #1; n = 0;
    while (!bvalid && n < TIMEOUT) begin @(negedge aclk); #1; n++; end
    checkOutput("b_valid", bvalid, 1);
    checkOutput("b_resp", bresp, err ? 2'b10 : 2'b00);
    checkOutput("b_id", bid, id);
    @(negedge aclk);
    bready = 1'b0; #1;
    checkOutput("b_done", bvalid, 0);
  endtask

  // stall_mode: 0 rready always high, 1 repeating 1-0-0-1, 2 random (mostly high).
  task automatic applyRead(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int stall_mode);
    logic [31:0] a;
    logic [38:0] held;
    bit cfg, oor, stalled;
    int beat, n;
    cfg = cfgBad(len, size, burst);
    @(negedge aclk);
    arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
    arlock = 2'($urandom_range(0, 1)); arcache = 4'($urandom); arprot = 3'($urandom);
    arvalid = 1'b1;
    #1; n = 0;
    while (!arready && n < TIMEOUT) begin @(negedge aclk); #1; n++; end
    checkOutput("ar_ready", arready, 1);
    if (!arready) begin arvalid = 1'b0; return; end
    @(negedge aclk);
    arvalid = 1'b0;
    beat = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 4 * (len + 1) + TIMEOUT && beat <= len; cyc++) begin
      if (cyc > 0) @(negedge aclk);
      case (stall_mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (cyc == 0) checkOutput("r_first_valid", rvalid, 1);
      if (stalled) checkOutput("r_hold", {rdata, rresp, rlast, rid}, held);
      stalled = 1'b0;
      if (rvalid && rready) begin
        a = beatAddr(addr, len, size, burst, beat);
        oor = !inRange(a);
        checkOutput("r_resp", rresp, (cfg || oor) ? 2'b10 : 2'b00);
        if (!cfg) checkOutput("r_data", rdata, oor ? 32'h0 : ref_mem[a[11:2]]);
        checkOutput("r_last", rlast, beat == len);
        checkOutput("r_id", rid, id);
        beat++;
      end else if (rvalid) begin
        stalled = 1'b1;
        held = {rdata, rresp, rlast, rid};
      end
    end
    checkOutput("r_beats", beat, len + 1);
    @(negedge aclk);
    rready = 1'b0; #1;
    checkOutput("r_done", rvalid, 0);
  endtask

  // Both address valids raised together for part of a cycle, then withdrawn before the edge.
  task automatic checkPriority(input bit expect_aw);
    @(negedge aclk);
    awaddr = '0; araddr = '0; awvalid = 1'b1; arvalid = 1'b1;
    #1;
    checkOutput("prio_awready", awready, expect_aw);
    checkOutput("prio_arready", arready, !expect_aw);
    #1;
    awvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic applyStimulus(input int count);
    int size, burst, len, bad_wid, bad_wlast;
    logic [31:0] addr;
    logic [3:0] id;
    for (int t = 0; t < count; t++) begin
      id    = 4'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (1 << $urandom_range(1, 4)) - 1;
      else len = $urandom_range(0, 15);
      addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 4 * MEM_WORDS + 64));
      addr = addr & ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 1) == 0) begin
        bad_wid   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1;
        bad_wlast = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1;
        applyWrite(id, addr, len, size, burst, 0, bad_wid, bad_wlast, $urandom_range(0, 3));
      end else begin
        applyRead(id, addr, len, size, burst, $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
    {wid, wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready} = '0;
    repeat (3) @(negedge aclk);
    #1;
    checkOutput("reset_outputs", allOutputs(), 0);
    @(negedge aclk);
    aresetn = 1'b1; #1;
    checkOutput("idle_outputs", allOutputs(), 0);
    checkPriority(1'b1);

    // Load the whole RAM so every model word is known.
    for (int w = 0; w < MEM_WORDS / 16; w++) applyWrite(4'h0, 32'(w * 64), 15, 2, 1, 1, -1, -1, 0);
    checkPriority(1'b0);

    applyWrite(4'h5, 32'h100, 3, 2, 1, 2, -1, -1, 0);
    checkPriority(1'b0);
    applyRead(4'h5, 32'h100, 3, 2, 1, 0);
    checkPriority(1'b1);

    applyWrite(4'h2, 32'h0, 3, 2, 1, 2, -1, -1, 1);
    applyRead(4'h2, 32'h0C, 3, 2, 2, 0);
    applyRead(4'h3, 32'h0, 2, 2, 2, 0);
    applyWrite(4'h3, 32'h40, 2, 2, 2, 1, -1, -1, 0);
    applyRead(4'h3, 32'h40, 3, 2, 1, 0);

    applyWrite(4'h7, 32'(MEM_WORDS * 4), 0, 2, 1, 1, -1, -1, 0);
    applyRead(4'h7, 32'(MEM_WORDS * 4), 0, 2, 1, 0);
    applyRead(4'h7, 32'h0, 3, 2, 1, 0);

    applyWrite(4'h9, 32'h300, 7, 2, 1, 1, -1, -1, 5);
    applyRead(4'h9, 32'h300, 7, 2, 1, 1);
    applyWrite(4'hA, 32'h380, 5, 2, 1, 1, 2, -1, 0);
    applyWrite(4'hB, 32'h3A0, 5, 2, 1, 1, -1, 1, 0);
    applyWrite(4'hC, 32'h3C0, 3, 2, 1, 1, -1, 3, 0);
    applyRead(4'hA, 32'h380, 15, 2, 1, 2);
    applyWrite(4'hD, 32'h500, 3, 0, 1, 0, -1, -1, 0);
    applyRead(4'hD, 32'h500, 1, 2, 0, 0);

    // Reset in the middle of a write burst: beat 0 lands, the rest is abandoned.
    @(negedge aclk);
    awid = 4'h6; awaddr = 32'h200; awlen = 4'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    #1;
    checkOutput("rst_awready", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b1; wid = 4'h6; wdata = 32'hCAFE_0001; wstrb = 4'hF; wlast = 1'b0;
    #1;
    checkOutput("rst_wready", wready, 1);
    ref_mem[128] = 32'hCAFE_0001;
    @(negedge aclk);
    wdata = 32'hCAFE_0002; aresetn = 1'b0;
    #1;
    checkOutput("rst_outputs", allOutputs(), 0);
    @(negedge aclk);
    wvalid = 1'b0; aresetn = 1'b1;
    #1;
    checkOutput("rst_idle", allOutputs(), 0);
    checkPriority(1'b1);
    applyWrite(4'h1, 32'h600, 1, 2, 1, 1, -1, -1, 0);
    applyRead(4'h6, 32'h200, 3, 2, 1, 0);

    applyStimulus(80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
